// File: rtl/seg_scan_ctrl.sv
//==============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed seven-segment scan controller. Upstream logic
//               writes digits into a shadow bank via valid/ready and commits
//               them as a unit. The shadow bank is copied to the active bank
//               only at a frame boundary, so no partial update is ever shown.
//               Optional macro SEG_DP_EN adds a per-digit decimal point.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [IDX_W-1:0]      upd_idx,
  input  logic [2:0]            upd_code,
  input  logic                  upd_sym,
  input  logic                  upd_commit,
`ifdef SEG_DP_EN
  input  logic                  upd_dp,
  output logic                  dp,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic [IDX_W-1:0]      cur_idx
);

  // Entry layout: {[dp,] sym, code[2:0]}
`ifdef SEG_DP_EN
  localparam int c_ent_w = 5;
`else
  localparam int c_ent_w = 4;
`endif

  localparam logic [CNT_W-1:0]      c_blank_last = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]      c_scan_last  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      c_last_idx   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_one        = NUM_DIGITS'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        r_cur_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              r_seg;
  logic [6:0]              w_seg_nxt;
  logic                    w_wrap;
  logic                    r_pending;
  logic [c_ent_w-1:0]      r_shadow [NUM_DIGITS];
  logic [c_ent_w-1:0]      r_active [NUM_DIGITS];
  logic [c_ent_w-1:0]      w_cur_ent;
  logic [c_ent_w-1:0]      w_wr_ent;

`ifdef SEG_DP_EN
  logic r_dp;
  logic w_dp_nxt;
  assign w_wr_ent = {upd_dp, upd_sym, upd_code};
  assign dp       = r_dp;
`else
  assign w_wr_ent = {upd_sym, upd_code};
`endif

  assign w_cur_ent = r_active[r_cur_idx];
  assign upd_ready = ~r_pending;
  assign an        = r_an;
  assign seg       = r_seg;
  assign cur_idx   = r_cur_idx;

  // Active-low seven-segment pattern {a..g}; an invalid symbol or code 0 is blank
  function automatic logic [6:0] seg_decode(input logic sym, input logic [2:0] code);
    logic [6:0] pat;
    pat = 7'b1111111;
    if (sym) begin
      case (code)
        3'd1:    pat = 7'b1001111;
        3'd2:    pat = 7'b0010010;
        3'd3:    pat = 7'b0000110;
        3'd4:    pat = 7'b1001100;
        3'd5:    pat = 7'b0100100;
        3'd6:    pat = 7'b1100000;
        3'd7:    pat = 7'b0001111;
        default: pat = 7'b1111111;
      endcase
    end
    return pat;
  endfunction

  // Scan FSM state, phase counter, digit index and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_cur_idx <= '0;
      r_an      <= '1;
      r_seg     <= '1;
`ifdef SEG_DP_EN
      r_dp      <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_idx <= w_idx_nxt;
      r_an      <= w_an_nxt;
      r_seg     <= w_seg_nxt;
`ifdef SEG_DP_EN
      r_dp      <= w_dp_nxt;
`endif
    end
  end

  // Next state and next outputs; outputs follow the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_cur_idx;
    w_wrap      = 1'b0;
    w_an_nxt    = '1;
    w_seg_nxt   = 7'b1111111;
`ifdef SEG_DP_EN
    w_dp_nxt    = 1'b1;
`endif
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_scan_last) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_cur_idx + 1'b1;
          w_wrap      = (r_cur_idx == c_last_idx);
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
    // The index only changes when leaving DRIVE, so r_cur_idx is the digit
    // that will be driven whenever the next state is DRIVE.
    if (w_state_nxt == ST_DRIVE) begin
      w_an_nxt  = ~(c_one << r_cur_idx);
      w_seg_nxt = seg_decode(w_cur_ent[3], w_cur_ent[2:0]);
`ifdef SEG_DP_EN
      w_dp_nxt  = ~w_cur_ent[4];
`endif
    end
  end

  // Shadow writes, commit handshake and tear-free bank swap at frame wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '{default: '0};
      r_active  <= '{default: '0};
      r_pending <= 1'b0;
    end else begin
      // Writes are blocked while pending, so the swap never races a write
      if (w_wrap && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (upd_valid && !r_pending) begin
        r_shadow[upd_idx] <= w_wr_ent;
      end
      if (upd_commit && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
//==============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl. Expected outputs come
//               from a time-slot model: position in the frame is derived from
//               the number of clock edges since reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int IW    = 2;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int CW    = 16;
  localparam int SLOT  = BC + SD;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [IW-1:0] upd_idx = '0;
  logic [2:0]    upd_code = '0;
  logic          upd_sym = 1'b0;
  logic          upd_commit = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic [IW-1:0] cur_idx;
`ifdef SEG_DP_EN
  logic          upd_dp = 1'b0;
  logic          dp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND), .IDX_W(IW), .SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_idx    (upd_idx),
    .upd_code   (upd_code),
    .upd_sym    (upd_sym),
    .upd_commit (upd_commit),
`ifdef SEG_DP_EN
    .upd_dp     (upd_dp),
    .dp         (dp),
`endif
    .an         (an),
    .seg        (seg),
    .cur_idx    (cur_idx)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit       m_sh_sym [ND];
  bit [2:0] m_sh_code[ND];
  bit       m_ac_sym [ND];
  bit [2:0] m_ac_code[ND];
  bit       m_sh_dp  [ND];
  bit       m_ac_dp  [ND];
  bit       m_pend;
  int       k;   // clock edges since the last reset edge

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h k=%0d t=%0t", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input bit sym, input bit [2:0] code);
    logic [6:0] tbl [8];
    tbl = '{7'b1111111, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b1100000, 7'b0001111};
    return sym ? tbl[code] : 7'b1111111;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_sh_sym[i] = 0; m_sh_code[i] = 0; m_sh_dp[i] = 0;
      m_ac_sym[i] = 0; m_ac_code[i] = 0; m_ac_dp[i] = 0;
    end
    m_pend = 0;
    k = 0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT samples
  task automatic model_edge();
    bit old_p;
    if (!rst_n) begin
      model_reset();
    end else begin
      old_p = m_pend;
      k++;
      if ((k % FRAME == 0) && old_p) begin
        for (int i = 0; i < ND; i++) begin
          m_ac_sym[i] = m_sh_sym[i]; m_ac_code[i] = m_sh_code[i]; m_ac_dp[i] = m_sh_dp[i];
        end
        m_pend = 0;
      end
      if (upd_valid && !old_p) begin
        m_sh_sym[upd_idx]  = upd_sym;
        m_sh_code[upd_idx] = upd_code;
`ifdef SEG_DP_EN
        m_sh_dp[upd_idx]   = upd_dp;
`endif
      end
      if (upd_commit && !old_p) m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    int         slot;
    int         dig;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    slot = k % SLOT;
    dig  = (k / SLOT) % ND;
    if (slot < BC) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      exp_an  = ~(4'b0001 << dig);
      exp_seg = ref_seg(m_ac_sym[dig], m_ac_code[dig]);
    end
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("cur_idx", 32'(cur_idx), 32'(dig));
    check_eq("upd_ready", 32'(upd_ready), 32'(!m_pend));
`ifdef SEG_DP_EN
    check_eq("dp", 32'(dp), (slot < BC) ? 32'd1 : 32'(!m_ac_dp[dig]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    upd_valid = 0; upd_commit = 0;
  endtask

  task automatic write_digit(input int idx, input int code, input bit sym, input bit commit);
    upd_valid = 1; upd_idx = IW'(idx); upd_code = 3'(code); upd_sym = sym; upd_commit = commit;
    step();
    idle_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    // Reset, then release and observe the raw scan sequence
    rst_n = 0;
    run(2);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    rst_n = 1;
    run(FRAME + 3);

    // Write + commit in one cycle; ready must drop immediately
    write_digit(2, 5, 1, 1);
    check_eq("ready_drop", 32'(upd_ready), 32'd0);
    // Ignored handshake while ready is low
    write_digit(0, 3, 1, 1);
    run(2 * FRAME);
    check_eq("ready_back", 32'(upd_ready), 32'd1);

    // Tear-free: commit while digit 1 is driving
    write_digit(1, 7, 1, 0);
    write_digit(3, 2, 1, 0);
    for (int i = 0; i < FRAME && (k % FRAME) != SLOT + BC + 1; i++) step();
    upd_commit = 1; step(); idle_inputs();
    run(2 * FRAME);

    // Blanking cases
    write_digit(0, 7, 0, 1);
    run(2 * FRAME);
    write_digit(0, 0, 1, 1);
    run(2 * FRAME);

    // Reset during DRIVE of digit 3 with a commit pending
    write_digit(0, 4, 1, 1);
    for (int i = 0; i < FRAME && (k % FRAME) != 3 * SLOT + BC + 1; i++) step();
    check_eq("pend_before_rst", 32'(upd_ready), 32'd0);
    rst_n = 0; step(); rst_n = 1;
    check_eq("mid_rst_an", 32'(an), 32'hF);
    check_eq("mid_rst_ready", 32'(upd_ready), 32'd1);
    run(FRAME + 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      rst_n      = ($urandom % 400) != 0;
      upd_valid  = $urandom % 2;
      upd_idx    = IW'($urandom);
      upd_code   = 3'($urandom);
      upd_sym    = ($urandom % 4) != 0;
      upd_commit = ($urandom % 16) == 0;
`ifdef SEG_DP_EN
      upd_dp     = $urandom % 2;
`endif
      step();
    end
    rst_n = 1;
    idle_inputs();
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one seven-segment decoder and one segment bus among NUM_DIGITS digits. Each digit holds a 3-bit priority-encoder code plus valid flag.
Upstream logic writes digits into a shadow bank through a valid/ready handshake and commits them as a unit. The controller swaps the shadow bank in at a frame boundary, so the display never shows a partial update.

Parameters:
NUM_DIGITS, 4, number of digits scanned; power of 2, range 2..8
IDX_W, 2, digit index width; equals log2(NUM_DIGITS)
SCAN_DIV, 50000, clk cycles each digit is driven; must be >= 1
BLANK_CYC, 16, all-off dead-time cycles before each digit (anti-ghosting); must be >= 1
CNT_W, 16, phase counter width; must hold max(SCAN_DIV, BLANK_CYC)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
upd_valid  in  1  digit write request
upd_ready  out  1  write/commit may be accepted
upd_idx  in  IDX_W  digit index to write
upd_code  in  3  encoder code for the digit
upd_sym  in  1  encoder valid flag; 0 forces the digit blank
upd_commit  in  1  single-cycle request to publish the shadow bank
an  out  NUM_DIGITS  digit enables, active-low, one-hot-low when driving
seg  out  7  segments, active-low, {a..g}
cur_idx  out  IDX_W  digit currently selected

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - FSM=BLANK, cur_idx=0, counter=0.
  - Shadow and active banks cleared to {sym=0, code=0}; commit-pending cleared.
  - an=all ones, seg=7'b1111111, upd_ready=1.
  - Reset mid-frame or mid-handshake discards everything.
- Write: accepted when upd_valid & upd_ready.
  - Shadow[upd_idx] <= {upd_sym, upd_code} at that edge.
  - Out-of-range indices cannot occur (power-of-2 NUM_DIGITS).
- Commit: accepted when upd_commit & upd_ready. Sets pending=1; upd_ready <= 0 on the same edge.
  - Write and commit in the same cycle: the write lands in shadow and is included in the commit.
  - upd_commit while upd_ready=0 is ignored.
- FSM states: BLANK, DRIVE.
  - BLANK: an=all ones, seg=7'b1111111 for BLANK_CYC cycles, then -> DRIVE with counter reset.
  - DRIVE: an[cur_idx]=0, others 1; seg=decode(active[cur_idx]) for SCAN_DIV cycles.
  - At the end of DRIVE: -> BLANK and cur_idx <= cur_idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary: the DRIVE-to-BLANK edge where cur_idx wraps to 0.
  - If pending: active <= shadow for all digits, pending <= 0, upd_ready <= 1 on that edge.
  - Shadow is not cleared by a commit.
- Output timing:
  - an, seg, cur_idx are registered.
  - First DRIVE after reset: an becomes 4'b1110 at the edge after BLANK_CYC cycles and holds for SCAN_DIV cycles.
  - Frame period = NUM_DIGITS*(BLANK_CYC+SCAN_DIV) cycles.
- Decode (active-low): sym=0 or code=0 -> 1111111
  - code 1 -> 1001111
  - code 2 -> 0010010
  - code 3 -> 0000110
  - code 4 -> 1001100
  - code 5 -> 0100100
  - code 6 -> 1100000
  - code 7 -> 0001111
- Commit latency: commit to new data on digit 0 is at most one frame plus BLANK_CYC+1 cycles.
- Counter: increments by 1 per cycle and is cleared on each state change. It never wraps; CNT_W is sized by parameter.

Optional Feature:
SEG_DP_EN
- Defined:
  - Adds input upd_dp (1 bit) and output dp (1 bit, active-low).
  - Shadow and active entries widen by one bit; upd_dp is written with the digit.
  - dp=~active[cur_idx].dp in DRIVE and 1 in BLANK and reset.
  - dp is independent of sym.
- Undefined: no dp ports and no extra storage; behaviour otherwise identical.

Test Plan:
- Reset/scan (BLANK_CYC=2, SCAN_DIV=4, NUM_DIGITS=4):
  - Release rst_n -> an=1111 and seg=1111111 for 2 cycles, then an=1110 for 4 cycles, blank 2, then an=1101.
  - cur_idx sequence 0,1,2,3,0; period 24 cycles.
- Write+commit same cycle: idx=2, code=5, sym=1 -> upd_ready drops next edge.
  - At next wrap, digit 2 DRIVE shows seg=0100100; upd_ready returns to 1 at that wrap edge.
- Tear-free update: commit mid-frame while digit 1 is driving.
  - Digits 1..3 in this frame show old values; new values first appear on digit 0 of the next frame.
- Blanking: write idx=0 with sym=0, code=7, then commit -> digit 0 DRIVE shows seg=1111111.
  - Write code=0, sym=1 -> also 1111111.
- Ignored handshake: pulse upd_commit and upd_valid while upd_ready=0.
  - Shadow is unchanged and no second commit occurs; the display after the next wrap matches the first commit only.
- Reset mid-operation: assert rst_n=0 for 1 cycle during DRIVE of digit 3 with a commit pending.
  - Next cycle: an=1111, seg=1111111, cur_idx=0, upd_ready=1; all digits blank after restart.
